// File: rtl/prog_run_sequencer_if.sv
// rtl/prog_run_sequencer_if.sv - go/all_done handshake and datapath START/DONE bundle for the run sequencer
interface prog_run_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic             dp_done;
    logic             dp_start;
    logic [3:0]       prog_idx;
    logic             busy;
    logic [CNT_W-1:0] cycle_count;
    logic             count_valid;
    logic             timeout;
    logic             all_done;

    // master: the top level / datapath side that requests sequences and reports DONE
    modport master (
        output go,
        output dp_done,
        input  dp_start,
        input  prog_idx,
        input  busy,
        input  cycle_count,
        input  count_valid,
        input  timeout,
        input  all_done
    );

    // slave: the sequencer itself
    modport slave (
        input  go,
        input  dp_done,
        output dp_start,
        output prog_idx,
        output busy,
        output cycle_count,
        output count_valid,
        output timeout,
        output all_done
    );
endinterface

// File: rtl/prog_run_sequencer.sv
// rtl/prog_run_sequencer.sv - runs NUM_PROGS datapath programs back-to-back with start hold, run timing and watchdog
module prog_run_sequencer #(
    parameter int               NUM_PROGS    = 3,
    parameter int               START_CYCLES = 2,
    parameter int               CNT_W        = 16,
    parameter logic [CNT_W-1:0] TIMEOUT      = 16'hFFFF
) (
    input  logic                CLK,
    input  logic                reset,
    prog_run_sequencer_if.slave bus
);
    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0]  START_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [3:0]       LAST_PROG  = 4'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START_S = 2'd1,
        RUN     = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t           state;
    logic [SC_W-1:0]  start_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_len;
    logic             run_limit;

    // run_len is the 1-based index of the current RUN cycle
    assign run_len   = run_cnt + ONE;
    assign run_limit = (run_len == TIMEOUT);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state           <= IDLE;
            start_cnt       <= '0;
            run_cnt         <= '0;
            bus.dp_start    <= 1'b1;
            bus.prog_idx    <= 4'd0;
            bus.busy        <= 1'b0;
            bus.cycle_count <= '0;
            bus.count_valid <= 1'b0;
            bus.timeout     <= 1'b0;
            bus.all_done    <= 1'b0;
        end else begin
            bus.count_valid <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    bus.dp_start <= 1'b1;
                    if (bus.go) begin
                        state        <= START_S;
                        start_cnt    <= '0;
                        bus.prog_idx <= 4'd0;
                        bus.timeout  <= 1'b0;
                        bus.busy     <= 1'b1;
                        bus.all_done <= 1'b0;
                    end
                end

                START_S: begin
                    bus.dp_start <= 1'b1;
                    bus.busy     <= 1'b1;
                    if (start_cnt == START_LAST) begin
                        state        <= RUN;
                        run_cnt      <= '0;
                        bus.dp_start <= 1'b0;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end

                RUN: begin
                    bus.dp_start <= 1'b0;
                    bus.busy     <= 1'b1;
                    // A DONE in the limit cycle wins over the watchdog
                    if (bus.dp_done || run_limit) begin
                        bus.cycle_count <= run_len;
                        bus.count_valid <= 1'b1;
                        if (!bus.dp_done) begin
                            bus.timeout <= 1'b1;
                        end
                        bus.dp_start <= 1'b1;
                        if (bus.prog_idx == LAST_PROG) begin
                            state        <= FINISH;
                            bus.busy     <= 1'b0;
                            bus.all_done <= 1'b1;
                        end else begin
                            state        <= START_S;
                            start_cnt    <= '0;
                            bus.prog_idx <= bus.prog_idx + 4'd1;
                        end
                    end else begin
                        run_cnt <= run_len;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.dp_start <= 1'b1;
                    bus.busy     <= 1'b0;
                    bus.all_done <= 1'b0;
                end
            endcase
        end
    end
endmodule
